// File: rtl/ddr_line_responder.sv
// Line-granular DDR responder: buffers one cache read and one cache write request, then issues them
// one at a time to the MIG user interface and returns completion pulses to the cache.
module ddr_line_responder #(
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned ALIGN_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     cache2DDR_rd_addr,
  input  logic                  cache2DDR_rd_en,
  output logic                  DDR2cache_rd_fin,
  output logic [LINE_W-1:0]     DDR2cache_rd_data,
  input  logic [ADDR_W-1:0]     cache2DDR_wr_addr,
  input  logic [LINE_W-1:0]     cache2DDR_wr_data,
  input  logic                  cache2DDR_wr_en,
  output logic                  DDR2cache_wr_fin,
  input  logic                  init_calib_complete,
  output logic [ADDR_W-1:0]     app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [LINE_W-1:0]     app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [LINE_W/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_rdy,
  input  logic [LINE_W-1:0]     app_rd_data,
  input  logic                  app_rd_data_valid
);

  localparam logic [2:0] CmdRead  = 3'b001;
  localparam logic [2:0] CmdWrite = 3'b000;
  localparam logic [ADDR_W-1:0] AlignMask = {{(ADDR_W-ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};

  typedef enum logic [2:0] {StIdle, StRdCmd, StRdWait, StRdFin, StWrCmd, StWrFin} state_e;

  state_e state_q, state_d;

  logic              rd_full_q, wr_full_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [LINE_W-1:0] wr_data_q;
  logic              wr_older_q;
  logic              rd_outstanding_q;
  logic              cmd_done_q, wdf_done_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [LINE_W-1:0] wdf_data_q;
  logic [LINE_W-1:0] rd_data_q;

  logic take_rd, take_wr;
  logic rd_remain, wr_remain;
  logic cmd_hs, wdf_hs;
  logic rd_beat;

  // The older slot wins; a lone full slot is always taken.
  assign take_rd = (state_q == StIdle) && init_calib_complete && rd_full_q &&
                   (!wr_full_q || !wr_older_q);
  assign take_wr = (state_q == StIdle) && init_calib_complete && wr_full_q &&
                   (!rd_full_q || wr_older_q);

  assign rd_remain = rd_full_q && !take_rd;
  assign wr_remain = wr_full_q && !take_wr;
  assign cmd_hs    = app_en && app_rdy;
  assign wdf_hs    = app_wdf_wren && app_wdf_rdy;
  assign rd_beat   = app_rd_data_valid && rd_outstanding_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (take_wr) begin
          state_d = StWrCmd;
        end else if (take_rd) begin
          state_d = StRdCmd;
        end
      end
      StRdCmd:  if (app_rdy) state_d = StRdWait;
      StRdWait: if (rd_beat) state_d = StRdFin;
      StRdFin:  state_d = StIdle;
      StWrCmd:  if ((cmd_done_q || cmd_hs) && (wdf_done_q || wdf_hs)) state_d = StWrFin;
      StWrFin:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    app_en           = 1'b0;
    app_wdf_wren     = 1'b0;
    app_cmd          = CmdWrite;
    DDR2cache_rd_fin = 1'b0;
    DDR2cache_wr_fin = 1'b0;
    unique case (state_q)
      StRdCmd: begin
        app_en  = 1'b1;
        app_cmd = CmdRead;
      end
      StWrCmd: begin
        app_en       = !cmd_done_q;
        app_wdf_wren = !wdf_done_q;
      end
      StRdFin: DDR2cache_rd_fin = 1'b1;
      StWrFin: DDR2cache_wr_fin = 1'b1;
      default: ;
    endcase
    app_wdf_end = app_wdf_wren;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_full_q        <= 1'b0;
      wr_full_q        <= 1'b0;
      rd_addr_q        <= '0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      wr_older_q       <= 1'b0;
      rd_outstanding_q <= 1'b0;
      cmd_done_q       <= 1'b0;
      wdf_done_q       <= 1'b0;
      cmd_addr_q       <= '0;
      wdf_data_q       <= '0;
      rd_data_q        <= '0;
    end else begin
      rd_full_q <= rd_remain || cache2DDR_rd_en;
      wr_full_q <= wr_remain || cache2DDR_wr_en;
      if (cache2DDR_rd_en) rd_addr_q <= cache2DDR_rd_addr;
      if (cache2DDR_wr_en) begin
        wr_addr_q <= cache2DDR_wr_addr;
        wr_data_q <= cache2DDR_wr_data;
      end
      // A slot left waiting is older than anything arriving; simultaneous arrivals favour the write.
      if (!rd_remain && !wr_remain) begin
        wr_older_q <= cache2DDR_wr_en;
      end else if (rd_remain && !wr_remain) begin
        wr_older_q <= 1'b0;
      end else if (wr_remain && !rd_remain) begin
        wr_older_q <= 1'b1;
      end
      if (take_rd) cmd_addr_q <= rd_addr_q & AlignMask;
      if (take_wr) begin
        cmd_addr_q <= wr_addr_q & AlignMask;
        wdf_data_q <= wr_data_q;
        cmd_done_q <= 1'b0;
        wdf_done_q <= 1'b0;
      end else if (state_q == StWrCmd) begin
        if (cmd_hs) cmd_done_q <= 1'b1;
        if (wdf_hs) wdf_done_q <= 1'b1;
      end
      if (state_q == StRdCmd && app_rdy) begin
        rd_outstanding_q <= 1'b1;
      end else if (rd_beat) begin
        rd_outstanding_q <= 1'b0;
      end
      if (rd_beat) rd_data_q <= app_rd_data;
    end
  end

  assign app_addr          = cmd_addr_q;
  assign app_wdf_data      = wdf_data_q;
  assign app_wdf_mask      = '0;
  assign DDR2cache_rd_data = rd_data_q;

endmodule
